// File: rtl/bandgap_ctrl.sv
// Enable sequencer for the analog bandgap reference.
// It arbitrates demand, times settling and the minimum off-time, and grants consumers with a req/ack handshake.
module bandgap_ctrl #(
   parameter int SETTLE_CYCLES = 1000,
   parameter int HOLD_CYCLES   = 64,
   parameter int NREQ          = 4,
   parameter int CNT_W         = 16
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            sw_en_i,
   input  logic [NREQ-1:0] req_i,
   output logic            bg_en_o,
   output logic            ready_o,
   output logic [NREQ-1:0] ack_o,
   output logic [1:0]      state_o,
   output logic [7:0]      en_count_o
);

   typedef enum logic [1:0] {
      S_OFF    = 2'd0,
      S_SETTLE = 2'd1,
      S_ON     = 2'd2,
      S_COOL   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        en_count_q, en_count_d;
   logic              bg_en_q, bg_en_d;
   logic              ready_q, ready_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic              demand;

   assign demand = sw_en_i | (|req_i);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= S_OFF;
         cnt_q      <= '0;
         en_count_q <= '0;
         bg_en_q    <= 1'b0;
         ready_q    <= 1'b0;
         ack_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         en_count_q <= en_count_d;
         bg_en_q    <= bg_en_d;
         ready_q    <= ready_d;
         ack_q      <= ack_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      en_count_d = en_count_q;
      case (state_q)
         S_OFF: begin
            if (demand) begin
               state_d    = S_SETTLE;
               cnt_d      = SETTLE_LOAD;
               en_count_d = (en_count_q == 8'hFF) ? en_count_q : en_count_q + 8'd1;
            end
         end
         S_SETTLE: begin
            // Loss of demand wins over settle completion.
            if (!demand) begin
               state_d = S_COOL;
               cnt_d   = HOLD_LOAD;
            end else if (cnt_q == '0) begin
               state_d = S_ON;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_ON: begin
            if (!demand) begin
               state_d = S_COOL;
               cnt_d   = HOLD_LOAD;
            end
         end
         S_COOL: begin
            if (cnt_q == '0) begin
               state_d = S_OFF;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = S_OFF;
      endcase
   end

   // Outputs decode the next state so they move on the same edge as the transition.
   always_comb begin
      bg_en_d = (state_d == S_SETTLE) || (state_d == S_ON);
      ready_d = (state_d == S_ON);
      ack_d   = {NREQ{state_d == S_ON}} & req_i;
   end

   assign bg_en_o    = bg_en_q;
   assign ready_o    = ready_q;
   assign ack_o      = ack_q;
   assign state_o    = state_q;
   assign en_count_o = en_count_q;

endmodule

// File: tb/tb_bandgap_ctrl.sv
// Directed bench for bandgap_ctrl with SETTLE_CYCLES=8, HOLD_CYCLES=4.
module tb_bandgap_ctrl;
   localparam int S = 8;
   localparam int H = 4;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         sw_en;
   logic [N-1:0] req;
   logic         bg_en, ready;
   logic [N-1:0] ack;
   logic [1:0]   state;
   logic [7:0]   en_count;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   bandgap_ctrl #(.SETTLE_CYCLES(S), .HOLD_CYCLES(H), .NREQ(N), .CNT_W(16)) dut (
      .clk_i(clk), .reset_i(reset), .sw_en_i(sw_en), .req_i(req),
      .bg_en_o(bg_en), .ready_o(ready), .ack_o(ack), .state_o(state), .en_count_o(en_count)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; sw_en = 1'b0; req = '0;
      tick(3);
      reset = 1'b0;
      tick(2);
      chk("reset_state", 8'(state), 8'd0);
      chk("reset_bg_en", 8'(bg_en), 8'd0);
      chk("reset_ready", 8'(ready), 8'd0);
      chk("reset_ack", 8'(ack), 8'd0);
      chk("reset_en_count", en_count, 8'd0);
   endtask

   task automatic test_power_up();
      sw_en = 1'b1;
      tick(1);
      exp_cnt++;
      chk("pu_bg_en", 8'(bg_en), 8'd1);
      chk("pu_state_settle", 8'(state), 8'd1);
      chk("pu_en_count", en_count, 8'(exp_cnt));
      tick(S - 2);
      chk("pu_ready_early", 8'(ready), 8'd0);
      tick(1);
      chk("pu_ready_last_settle", 8'(ready), 8'd0);
      tick(1);
      chk("pu_ready", 8'(ready), 8'd1);
      chk("pu_state_on", 8'(state), 8'd2);
      chk("pu_ack_idle", 8'(ack), 8'd0);
   endtask

   task automatic test_ack();
      req = 4'b0100;
      tick(1);
      chk("ack2_rise", 8'(ack), 8'b0100);
      req = 4'b0000;
      tick(1);
      chk("ack2_fall", 8'(ack), 8'd0);
      chk("ack_state_on", 8'(state), 8'd2);
   endtask

   task automatic test_on_to_cool();
      req = 4'b0001;
      tick(1);
      chk("ack0_rise", 8'(ack), 8'b0001);
      sw_en = 1'b0; req = '0;
      tick(1);
      chk("cool_bg_en", 8'(bg_en), 8'd0);
      chk("cool_ready", 8'(ready), 8'd0);
      chk("cool_ack", 8'(ack), 8'd0);
      chk("cool_state", 8'(state), 8'd3);
      tick(H - 1);
      chk("cool_state_hold", 8'(state), 8'd3);
      tick(1);
      chk("cool_to_off", 8'(state), 8'd0);
   endtask

   task automatic test_abort_settle();
      logic saw_ready = 1'b0;
      sw_en = 1'b1;
      tick(1);
      exp_cnt++;
      chk("ab_state_settle", 8'(state), 8'd1);
      for (int i = 0; i < 3; i++) begin
         tick(1);
         saw_ready |= ready;
      end
      sw_en = 1'b0;
      tick(1);
      chk("ab_bg_en", 8'(bg_en), 8'd0);
      chk("ab_state_cool", 8'(state), 8'd3);
      sw_en = 1'b1;
      for (int i = 0; i < H - 1; i++) begin
         tick(1);
         saw_ready |= ready;
         chk("ab_cool_ignores_demand", 8'(state), 8'd3);
      end
      tick(1);
      chk("ab_off", 8'(state), 8'd0);
      chk("ab_off_bg_en", 8'(bg_en), 8'd0);
      chk("ab_ready_never", 8'(saw_ready), 8'd0);
      tick(1);
      exp_cnt++;
      chk("ab_restart", 8'(state), 8'd1);
      chk("ab_en_count", en_count, 8'(exp_cnt));
   endtask

   task automatic test_async_reset();
      tick(S);
      chk("ar_on", 8'(state), 8'd2);
      req = 4'b0010;
      tick(1);
      chk("ar_ack1", 8'(ack), 8'b0010);
      #3;
      reset = 1'b1;
      #1;
      chk("ar_bg_en", 8'(bg_en), 8'd0);
      chk("ar_ready", 8'(ready), 8'd0);
      chk("ar_ack", 8'(ack), 8'd0);
      chk("ar_count", en_count, 8'd0);
      #1;
      reset = 1'b0;
      tick(1);
      chk("ar_restart_state", 8'(state), 8'd1);
      chk("ar_restart_bg_en", 8'(bg_en), 8'd1);
      chk("ar_restart_count", en_count, 8'd1);
      exp_cnt = 1;
      sw_en = 1'b0; req = '0;
      tick(H + 2);
      chk("ar_back_off", 8'(state), 8'd0);
   endtask

   task automatic test_saturation();
      for (int p = 0; p < 300; p++) begin
         sw_en = 1'b1;
         tick(1);
         if (exp_cnt < 255) exp_cnt++;
         chk("sat_count", en_count, 8'(exp_cnt));
         sw_en = 1'b0;
         tick(H + 2);
      end
      chk("sat_final", en_count, 8'd255);
      chk("sat_off", 8'(state), 8'd0);
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_ack();
      test_on_to_cool();
      test_abort_settle();
      test_async_reset();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bandgap_ctrl.md
# bandgap_ctrl

Digital enable sequencer for the 3.3 V analog bandgap reference. It arbitrates reference demand from software and up to NREQ on-chip consumers (ADC, comparators, LDO), drives the bandgap EN pin, and holds a settling interval before declaring the reference valid. It also enforces a minimum off-time between power cycles and grants each consumer through a four-phase req/ack handshake. The block sits in the always-on digital domain beside the analog macro; its `bg_en` output connects directly to the bandgap EN input.

## Interface
- `SETTLE_CYCLES`, 1000: clock cycles from EN rise to reference valid; must be ≥1.
- `HOLD_CYCLES`, 64: minimum cycles EN stays low after any shutdown; must be ≥1.
- `NREQ`, 4: number of consumer request lines; must be ≥1.
- `CNT_W`, 16: down-counter width; must hold max(SETTLE_CYCLES, HOLD_CYCLES)−1.
- `clk` in 1: system clock; one clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `sw_en` in 1: software request, held level.
- `req` in NREQ: per-consumer reference request, four-phase.
- `bg_en` out 1: drives bandgap EN; registered.
- `ready` out 1: reference valid; registered.
- `ack` out NREQ: per-consumer grant; registered.
- `state` out 2: current FSM state (OFF=0, SETTLE=1, ON=2, COOL=3).
- `en_count` out 8: saturating count of OFF→SETTLE transitions.

## Operation
- Define `demand = sw_en | (|req)`, evaluated combinationally each cycle.
- OFF: `bg_en=0`, `ready=0`. If `demand`=1, go to SETTLE, load counter with SETTLE_CYCLES−1, and increment `en_count`. `en_count` saturates at 255.
- SETTLE: `bg_en=1`, `ready=0`.
  - If `demand`=0, go to COOL and load counter with HOLD_CYCLES−1. This check takes priority.
  - Else if counter==0, go to ON.
  - Otherwise decrement the counter.
- ON: `bg_en=1`, `ready=1`. If `demand`=0, go to COOL and load counter with HOLD_CYCLES−1.
- COOL: `bg_en=0`, `ready=0`. Demand is ignored.
  - If counter==0, go to OFF.
  - Otherwise decrement the counter.
  - A demand still present when OFF is reached restarts SETTLE on the following cycle.
- `bg_en`, `ready` and `state` are registered decodes of the next state, so they change on the same edge as the transition.
- `ack[i]` is the registered value of `next_state==ON & req[i]`.
  - A consumer must hold `req[i]` until it sees `ack[i]`, and may drop it at any time after.
  - `ack[i]` falls on the edge after `req[i]` falls, or on the edge that leaves ON.
- Consumers must not use the reference unless their `ack` bit is high. `ack` never asserts while `ready`=0.
- Reset values: state=OFF, `bg_en`=0, `ready`=0, `ack`=0, counter=0, `en_count`=0. Reset mid-operation drops `bg_en` immediately, and no HOLD interval is enforced after reset release.

## Timing
- `demand` sampled high at edge E0 (state OFF): `bg_en`=1 after E0; `ready` and the first `ack` rise after edge E0+SETTLE_CYCLES.
- Latency from `sw_en`/`req` rise to `ack` is SETTLE_CYCLES+1 edges from OFF. From ON it is 1 edge.
- Demand fall sampled at edge D0 in ON/SETTLE: `bg_en`, `ready` and all `ack` are low after D0.
  - OFF is entered after edge D0+HOLD_CYCLES.
  - The earliest re-enable is after edge D0+HOLD_CYCLES+1.
- A single-cycle demand pulse in OFF still produces a full SETTLE entry. When the pulse ends, the block goes to COOL; `en_count` increments once.
- `sw_en` and `req` rising or falling together are treated as one `demand` change. Only the OR matters.

## Test plan
- Reset, then `sw_en`=1 at cycle 5 (SETTLE_CYCLES=8, HOLD_CYCLES=4) -> `bg_en` high at cycle 6; `ready` high at cycle 14; `state`=2; `en_count`=1.
- `req[2]`=1 while ON -> `ack[2]`=1 exactly one edge later; drop `req[2]` -> `ack[2]`=0 one edge later; other ack bits stay 0 throughout.
- All demand removed at cycle 3 of SETTLE -> `bg_en`=0 next edge, `ready` never rises, `state`=3 for 4 cycles then 0; re-asserted `sw_en` during COOL -> SETTLE starts one edge after OFF, `en_count`=2.
- `req[0]` held across ON→COOL (caused by `sw_en` drop with `req[0]` dropping too) -> `ack[0]` and `ready` fall on the same edge as `bg_en`.
- 300 short demand pulses, each separated by >HOLD_CYCLES+1 idle cycles -> `en_count` saturates at 255 and never wraps.
- Assert `reset` asynchronously mid-ON -> `bg_en`, `ready` and `ack` go to 0 without a clock edge; after release with demand held, SETTLE restarts on the first edge.
